// File: rtl/gen_sequencer_pkg.sv
// Shared types for the generation sequencer: speed encoding, FSM states and
// the frame divisor helper.
`timescale 1ns/1ps
package gen_sequencer_pkg;

  typedef logic [7:0] speed_t;

  localparam speed_t SPEED_MAX = 8'hFF;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StStart,
    StCompute,
    StSwapWait,
    StSwap,
    StSettle
  } gen_state_t;

  // Frames per generation; 9 bits so SPEED_MAX - 0 + 1 cannot overflow.
  function automatic logic [8:0] gen_divisor(speed_t speed);
    return {1'b0, SPEED_MAX} - {1'b0, speed} + 9'd1;
  endfunction

endpackage

// File: rtl/gen_sequencer.sv
// Paces Game-of-Life generations against render frames and swaps buffers on
// frame boundaries. Optional GEN_COUNTER_EN adds a generation counter output.
`timescale 1ns/1ps
module gen_sequencer
  import gen_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd4194304,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  speed_t      speed_in,
  input  logic        pause_in,
  input  logic        step_in,
  input  logic        render_done_in,
  input  logic        logic_done_in,
  input  logic        buf_ready_in,
  output logic        logic_start_out,
  output logic        buf_swap_out,
  output logic        busy_out,
  output logic        timeout_out
`ifdef GEN_COUNTER_EN
  ,
  output logic [31:0] gen_count_out
`endif
);

  // SWAP counts as the first settle cycle, so SETTLE itself needs one fewer.
  localparam int unsigned SettleLast = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 1;

  gen_state_t  state;
  logic [8:0]  frame_cnt;
  logic        step_pending;
  logic [31:0] wdog;
  logic [31:0] settle_cnt;

  logic [8:0]  divisor;
  logic        run_go;
  logic        go;
  logic        step_ok;

  always_comb begin
    divisor = gen_divisor(speed_in);
    run_go  = !pause_in && (speed_in != '0) &&
              (({1'b0, frame_cnt} + 10'd1) >= {1'b0, divisor});
    go      = render_done_in && (run_go || step_pending);
    step_ok = step_in && (pause_in || (speed_in == '0));
  end

  assign busy_out = !(state inside {StInit, StIdle});

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= StInit;
      frame_cnt       <= '0;
      step_pending    <= 1'b0;
      wdog            <= '0;
      settle_cnt      <= '0;
      logic_start_out <= 1'b0;
      buf_swap_out    <= 1'b0;
      timeout_out     <= 1'b0;
`ifdef GEN_COUNTER_EN
      gen_count_out   <= '0;
`endif
    end else begin
      logic_start_out <= 1'b0;
      buf_swap_out    <= 1'b0;

      // Frames keep counting through a generation so the cadence stays fixed.
      if (render_done_in && (state != StInit) && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + 9'd1;
      end

      unique case (state)
        StInit: begin
          if (buf_ready_in) state <= StIdle;
        end
        StIdle: begin
          if (go) begin
            frame_cnt    <= '0;
            step_pending <= 1'b0;
            state        <= StStart;
          end else if (step_ok) begin
            step_pending <= 1'b1;
          end
        end
        StStart: begin
          logic_start_out <= 1'b1;
          wdog            <= '0;
          state           <= StCompute;
        end
        StCompute: begin
          if (logic_done_in) begin
            state <= StSwapWait;
          end else if (wdog == TIMEOUT_CYCLES - 1) begin
            timeout_out <= 1'b1;
            state       <= StIdle;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        StSwapWait: begin
          if (render_done_in && buf_ready_in) state <= StSwap;
        end
        StSwap: begin
          buf_swap_out <= 1'b1;
          settle_cnt   <= 32'd1;
`ifdef GEN_COUNTER_EN
          gen_count_out <= gen_count_out + 32'd1;
`endif
          state        <= StSettle;
        end
        StSettle: begin
          if ((settle_cnt >= SettleLast) && buf_ready_in) begin
            state <= StIdle;
          end else if (settle_cnt < SettleLast) begin
            settle_cnt <= settle_cnt + 32'd1;
          end
        end
        default: state <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_sequencer.sv
// Scoreboard bench for gen_sequencer: expected start/swap/timeout events are
// queued per test and matched by a monitor against the frame they occur in.
`timescale 1ns/1ps
module tb_gen_sequencer;
  import gen_sequencer_pkg::*;

  localparam int unsigned TO       = 64;
  localparam int unsigned ST       = 4;
  localparam int          GAP      = 100;
  localparam int          DONE_DLY = 40;

  logic   clk = 1'b0;
  logic   rst;
  speed_t speed;
  logic   pause, step, rd, done, buf_ready;
  logic   logic_start, buf_swap, busy, timeout;
`ifdef GEN_COUNTER_EN
  logic [31:0] gen_count;
`endif

  gen_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .SETTLE_CYCLES  (ST)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .speed_in        (speed),
    .pause_in        (pause),
    .step_in         (step),
    .render_done_in  (rd),
    .logic_done_in   (done),
    .buf_ready_in    (buf_ready),
    .logic_start_out (logic_start),
    .buf_swap_out    (buf_swap),
    .busy_out        (busy),
    .timeout_out     (timeout)
`ifdef GEN_COUNTER_EN
    ,
    .gen_count_out   (gen_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int frame_no = 0;
  int rd_cyc = 0;
  int last_start_cyc = 0;
  bit withhold = 1'b0;
  bit prev_to = 1'b0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Event code = kind*1000 + frame; kinds: 0 start, 1 swap, 2 timeout.
  task automatic expect_ev(input int kind, input int frame);
    exp_q.push_back(kind * 1000 + frame);
  endtask

  task automatic observe(input int kind);
    int e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind * 1000 + frame_no, -1);
    end else begin
      e = exp_q.pop_front();
      check("event", kind * 1000 + frame_no, e);
      if (kind == 0) begin
        check("start_latency", cyc - rd_cyc, 2);
        last_start_cyc = cyc;
      end else if (kind == 1) begin
        check("swap_latency", cyc - rd_cyc, 2);
      end else begin
        check("timeout_latency", cyc - last_start_cyc, TO);
      end
    end
  endtask

  task automatic frames(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) @(negedge clk);
      rd = 1'b1;
      frame_no++;
      rd_cyc = cyc;
      @(negedge clk);
      rd = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; buf_ready = 1'b1; pause = 1'b0; step = 1'b0; rd = 1'b0;
    speed = SPEED_MAX; withhold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    frame_no = 0;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; speed = SPEED_MAX; pause = 1'b0; step = 1'b0; rd = 1'b0;
    done = 1'b0; buf_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (logic_start) observe(0);
        if (buf_swap) observe(1);
        if (timeout && !prev_to) observe(2);
        prev_to = timeout;
      end
      forever begin
        @(negedge clk);
        if (logic_start && !withhold) begin
          repeat (DONE_DLY) @(negedge clk);
          done = 1'b1;
          @(negedge clk);
          done = 1'b0;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_start", int'(logic_start), 0);
    check("rst_swap", int'(buf_swap), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(timeout), 0);
`ifdef GEN_COUNTER_EN
    check("rst_gen_count", int'(gen_count), 0);
`endif

    // Full speed: start on a frame, swap on the next, repeat.
    do_reset();
    expect_ev(0, 1); expect_ev(1, 2); expect_ev(0, 3);
    expect_ev(1, 4); expect_ev(0, 5); expect_ev(1, 6);
    frames(6, GAP);
    drain("t1_queue_empty");

    // Divisor 4: starts on frames 4, 8, 12.
    do_reset();
    speed = SPEED_MAX - 8'd3;
    expect_ev(0, 4); expect_ev(1, 5); expect_ev(0, 8);
    expect_ev(1, 9); expect_ev(0, 12); expect_ev(1, 13);
    frames(13, GAP);
    drain("t2_queue_empty");

    // Paused: three steps coalesce; a step while running is ignored.
    do_reset();
    pause = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; @(negedge clk); step = 1'b0; repeat (2) @(negedge clk);
    end
    expect_ev(0, 1); expect_ev(1, 2); expect_ev(0, 11); expect_ev(1, 12);
    frames(3, GAP);
    pause = 1'b0;
    speed = SPEED_MAX - 8'd9;
    step = 1'b1; @(negedge clk); step = 1'b0;
    frames(9, GAP);
    drain("t3_queue_empty");

    // Watchdog: no done, timeout after TO cycles, no swap.
    do_reset();
    withhold = 1'b1;
    expect_ev(0, 1); expect_ev(2, 1);
    frames(1, GAP);
    repeat (10) @(negedge clk);
    check("t4_busy_compute", int'(busy), 1);
    repeat (80) @(negedge clk);
    check("t4_timeout_sticky", int'(timeout), 1);
    check("t4_back_idle", int'(busy), 0);
    drain("t4_queue_empty");

    // Done coincident with a frame, then buf_ready low across the next frame.
    do_reset();
    withhold = 1'b1;
    expect_ev(0, 1); expect_ev(1, 4);
    frames(1, GAP);
    repeat (49) @(negedge clk);
    rd = 1'b1; done = 1'b1; frame_no++; rd_cyc = cyc;
    @(negedge clk);
    rd = 1'b0; done = 1'b0;
    repeat (80) @(negedge clk);
    buf_ready = 1'b0;
    frames(1, 5);
    repeat (5) @(negedge clk);
    buf_ready = 1'b1;
    frames(1, GAP);
    drain("t5_queue_empty");

    // Reset mid-COMPUTE aborts; stays in INIT until buf_ready.
    do_reset();
    withhold = 1'b1;
    expect_ev(0, 1); expect_ev(0, 3); expect_ev(1, 4);
    frames(1, GAP);
    repeat (20) @(negedge clk);
    check("t6_busy_before", int'(busy), 1);
    buf_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_start", int'(logic_start), 0);
    check("t6_swap", int'(buf_swap), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_timeout", int'(timeout), 0);
    rst = 1'b0;
    frames(1, 30);
    repeat (10) @(negedge clk);
    check("t6_init_hold", int'(busy), 0);
    buf_ready = 1'b1;
    withhold = 1'b0;
    frames(2, GAP);
    drain("t6_queue_empty");

`ifdef GEN_COUNTER_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      expect_ev(0, 2 * i + 1);
      expect_ev(1, 2 * i + 2);
    end
    frames(10, GAP);
    drain("t7_queue_empty");
    check("t7_gen_count", int'(gen_count), 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
